etapa_busqueda: RTL and testbench

ETAPA_BUSQUEDA -- requirements
Module: etapa_busqueda

---
 rtl/etapa_busqueda.sv | 103 ++++++++++
 tb/tb_etapa_busqueda.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_busqueda.sv
`default_nettype none
// ============================================================================
// Module   : etapa_busqueda
// Purpose  : Instruction fetch stage (PC, IF/ID register, HLT detection)
// Revision : 1.0 - initial release
// ============================================================================
module etapa_busqueda #(
    parameter int unsigned ANCHO_PC     = 10,
    parameter int unsigned DIR_ARRANQUE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                salto_tomado,
    input  logic [ANCHO_PC-1:0] direccion_salto,
    input  logic [31:0]         instruccion,
    output logic [ANCHO_PC-1:0] direccion,
    output logic [31:0]         instruccion_id,
    output logic [ANCHO_PC-1:0] pc_mas_uno_id,
    output logic                valido_id,
    output logic                detenido,
    output logic [15:0]         contador_instr
);

    typedef enum logic [0:0] {
        EJECUTANDO = 1'b0,
        DETENIDO   = 1'b1
    } estado_t;

    localparam logic [ANCHO_PC-1:0] c_pc_arranque = ANCHO_PC'(DIR_ARRANQUE);
    localparam logic [31:0]         c_hlt         = 32'h0000_0000;

    estado_t             estado_q, estado_d;
    logic [ANCHO_PC-1:0] pc_q, pc_d;
    logic [31:0]         instr_id_q, instr_id_d;
    logic [ANCHO_PC-1:0] pc1_id_q, pc1_id_d;
    logic                valido_q, valido_d;
    logic [15:0]         contador_q, contador_d;
    logic [ANCHO_PC-1:0] w_pc_mas_uno;

    // Natural overflow of the PC width gives the required wrap-around
    assign w_pc_mas_uno = pc_q + ANCHO_PC'(1);

    always_comb begin
        estado_d   = estado_q;
        pc_d       = pc_q;
        instr_id_d = instr_id_q;
        pc1_id_d   = pc1_id_q;
        valido_d   = valido_q;
        contador_d = contador_q;

        if (salto_tomado) begin
            pc_d       = direccion_salto;
            instr_id_d = '0;
            pc1_id_d   = '0;
            valido_d   = 1'b0;
            estado_d   = EJECUTANDO;
        end else if (stall) begin
            // hold everything
        end else if (estado_q == EJECUTANDO) begin
            instr_id_d = instruccion;
            pc1_id_d   = w_pc_mas_uno;
            valido_d   = 1'b1;
            contador_d = (contador_q == 16'hFFFF) ? contador_q : contador_q + 16'd1;
            if (instruccion == c_hlt) begin
                estado_d = DETENIDO;
            end else begin
                pc_d = w_pc_mas_uno;
            end
        end else begin
            instr_id_d = '0;
            pc1_id_d   = '0;
            valido_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= EJECUTANDO;
            pc_q       <= c_pc_arranque;
            instr_id_q <= '0;
            pc1_id_q   <= '0;
            valido_q   <= 1'b0;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            instr_id_q <= instr_id_d;
            pc1_id_q   <= pc1_id_d;
            valido_q   <= valido_d;
            contador_q <= contador_d;
        end
    end

    assign direccion      = pc_q;
    assign instruccion_id = instr_id_q;
    assign pc_mas_uno_id  = pc1_id_q;
    assign valido_id      = valido_q;
    assign detenido       = (estado_q == DETENIDO);
    assign contador_instr = contador_q;

endmodule
`default_nettype wire

// File: tb/tb_etapa_busqueda.sv
`default_nettype none
// ============================================================================
// Module   : tb_etapa_busqueda
// Purpose  : Self-checking bench for etapa_busqueda (two start addresses)
// Revision : 1.0 - initial release
// ============================================================================
module tb_etapa_busqueda;

    logic        clk = 1'b0;
    logic        reset, stall, salto_tomado;
    logic [9:0]  direccion_salto;
    logic [31:0] instr_i [2];
    logic [9:0]  dir_o   [2];
    logic [31:0] id_o    [2];
    logic [9:0]  pc1_o   [2];
    logic        val_o   [2];
    logic        det_o   [2];
    logic [15:0] cnt_o   [2];

    logic [31:0] rom [1024];

    // Reference model state, one set per instance (start 0 and start 1023)
    logic [9:0]  m_pc   [2];
    logic [31:0] m_id   [2];
    logic [9:0]  m_pc1  [2];
    logic        m_v    [2];
    logic        m_halt [2];
    int          m_cnt  [2];
    int          m_start [2] = '{0, 1023};

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    etapa_busqueda #(.ANCHO_PC(10), .DIR_ARRANQUE(0)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .salto_tomado(salto_tomado),
        .direccion_salto(direccion_salto), .instruccion(instr_i[0]),
        .direccion(dir_o[0]), .instruccion_id(id_o[0]), .pc_mas_uno_id(pc1_o[0]),
        .valido_id(val_o[0]), .detenido(det_o[0]), .contador_instr(cnt_o[0])
    );

    etapa_busqueda #(.ANCHO_PC(10), .DIR_ARRANQUE(1023)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .salto_tomado(salto_tomado),
        .direccion_salto(direccion_salto), .instruccion(instr_i[1]),
        .direccion(dir_o[1]), .instruccion_id(id_o[1]), .pc_mas_uno_id(pc1_o[1]),
        .valido_id(val_o[1]), .detenido(det_o[1]), .contador_instr(cnt_o[1])
    );

    // Instruction memory samples the address on the falling edge
    always @(negedge clk) begin
        instr_i[0] = rom[dir_o[0]];
        instr_i[1] = rom[dir_o[1]];
    end

    task automatic load_program();
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
        rom[0] = 32'h8C010001;
        rom[1] = 32'h00211020;
        rom[2] = 32'h00441820;
        rom[3] = 32'h00622020;
    endtask

    // Drive one cycle and advance the behavioural model by the fetch rules
    task automatic step(input logic r, input logic st, input logic sal, input logic [9:0] ds);
        logic [31:0] w;
        reset = r; stall = st; salto_tomado = sal; direccion_salto = ds;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            w = rom[m_pc[k]];
            if (r) begin
                m_pc[k] = 10'(m_start[k]); m_id[k] = 0; m_pc1[k] = 0;
                m_v[k] = 0; m_halt[k] = 0; m_cnt[k] = 0;
            end else if (sal) begin
                m_pc[k] = ds; m_id[k] = 0; m_pc1[k] = 0; m_v[k] = 0; m_halt[k] = 0;
            end else if (st) begin
                // no change
            end else if (!m_halt[k]) begin
                m_id[k]  = w;
                m_pc1[k] = 10'((int'(m_pc[k]) + 1) % 1024);
                m_v[k]   = 1;
                m_cnt[k] = (m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535;
                if (w == 32'h0) m_halt[k] = 1;
                else m_pc[k] = m_pc1[k];
            end else begin
                m_id[k] = 0; m_pc1[k] = 0; m_v[k] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        load_program();
        step(1, 0, 0, 0);
        step(1, 1, 1, 10'd7);
        tests_run++; if (dir_o[0] !== 10'd0) begin tests_failed++; $display("FAIL reset_pc got %0d want 0", dir_o[0]); end
        tests_run++; if (dir_o[1] !== 10'd1023) begin tests_failed++; $display("FAIL reset_pc_1023 got %0d want 1023", dir_o[1]); end
        tests_run++; if ({id_o[0], pc1_o[0], val_o[0], det_o[0], cnt_o[0]} !== '0) begin
            tests_failed++; $display("FAIL reset_regs got id=%h pc1=%0d v=%b det=%b cnt=%0d want all 0",
                                     id_o[0], pc1_o[0], val_o[0], det_o[0], cnt_o[0]);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_id [5] = '{32'h8C010001, 32'h00211020, 32'h00441820, 32'h00622020, 32'h0};
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            tests_run++; if (id_o[0] !== exp_id[i] || pc1_o[0] !== 10'(i + 1) || val_o[0] !== 1'b1) begin
                tests_failed++; $display("FAIL seq_fetch%0d got id=%h pc1=%0d v=%b want id=%h pc1=%0d v=1",
                                         i, id_o[0], pc1_o[0], val_o[0], exp_id[i], i + 1);
            end
        end
        step(0, 0, 0, 0);
        tests_run++; if (det_o[0] !== 1'b1 || dir_o[0] !== 10'd4 || cnt_o[0] !== 16'd5 || val_o[0] !== 1'b0) begin
            tests_failed++; $display("FAIL seq_halt got det=%b dir=%0d cnt=%0d v=%b want det=1 dir=4 cnt=5 v=0",
                                     det_o[0], dir_o[0], cnt_o[0], val_o[0]);
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            tests_run++; if (dir_o[0] !== 10'd2 || id_o[0] !== 32'h00211020 || cnt_o[0] !== 16'd2) begin
                tests_failed++; $display("FAIL stall_hold%0d got dir=%0d id=%h cnt=%0d want dir=2 id=00211020 cnt=2",
                                         i, dir_o[0], id_o[0], cnt_o[0]);
            end
        end
        step(0, 0, 0, 0);
        tests_run++; if (id_o[0] !== 32'h00441820) begin
            tests_failed++; $display("FAIL stall_release got id=%h want 00441820", id_o[0]);
        end
    endtask

    task automatic test_redirect();
        tests_run++; if (dir_o[0] !== 10'd3) begin tests_failed++; $display("FAIL redir_pre got dir=%0d want 3", dir_o[0]); end
        step(0, 1, 1, 10'd1);
        tests_run++; if (dir_o[0] !== 10'd1 || val_o[0] !== 1'b0 || id_o[0] !== 32'h0) begin
            tests_failed++; $display("FAIL redir_bubble got dir=%0d v=%b id=%h want dir=1 v=0 id=0", dir_o[0], val_o[0], id_o[0]);
        end
        step(0, 0, 0, 0);
        tests_run++; if (id_o[0] !== 32'h00211020 || pc1_o[0] !== 10'd2 || val_o[0] !== 1'b1) begin
            tests_failed++; $display("FAIL redir_fetch got id=%h pc1=%0d v=%b want id=00211020 pc1=2 v=1", id_o[0], pc1_o[0], val_o[0]);
        end
    endtask

    task automatic run_to_halt(input string name);
        int n = 0;
        while (det_o[0] !== 1'b1 && n < 20) begin step(0, 0, 0, 0); n++; end
        tests_run++; if (det_o[0] !== 1'b1) begin tests_failed++; $display("FAIL %s_timeout got det=%b want 1", name, det_o[0]); end
    endtask

    task automatic test_halt_exit();
        run_to_halt("halt_exit");
        step(0, 0, 1, 10'd0);
        tests_run++; if (det_o[0] !== 1'b0 || dir_o[0] !== 10'd0) begin
            tests_failed++; $display("FAIL halt_exit got det=%b dir=%0d want det=0 dir=0", det_o[0], dir_o[0]);
        end
        step(0, 0, 0, 0);
        tests_run++; if (id_o[0] !== 32'h8C010001 || val_o[0] !== 1'b1) begin
            tests_failed++; $display("FAIL halt_exit_fetch got id=%h v=%b want id=8C010001 v=1", id_o[0], val_o[0]);
        end
    endtask

    task automatic test_reset_in_halt();
        run_to_halt("reset_halt");
        step(1, 1, 1, 10'd5);
        tests_run++; if (dir_o[0] !== 10'd0 || {id_o[0], pc1_o[0], val_o[0], det_o[0], cnt_o[0]} !== '0) begin
            tests_failed++; $display("FAIL reset_in_halt got dir=%0d id=%h pc1=%0d v=%b det=%b cnt=%0d want all 0",
                                     dir_o[0], id_o[0], pc1_o[0], val_o[0], det_o[0], cnt_o[0]);
        end
    endtask

    task automatic test_wrap();
        rom[1023] = 32'h00211020;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        tests_run++; if (id_o[1] !== 32'h00211020 || pc1_o[1] !== 10'd0 || dir_o[1] !== 10'd0) begin
            tests_failed++; $display("FAIL wrap got id=%h pc1=%0d dir=%0d want id=00211020 pc1=0 dir=0", id_o[1], pc1_o[1], dir_o[1]);
        end
        step(0, 0, 0, 0);
        tests_run++; if (id_o[1] !== 32'h8C010001 || pc1_o[1] !== 10'd1) begin
            tests_failed++; $display("FAIL wrap_next got id=%h pc1=%0d want id=8C010001 pc1=1", id_o[1], pc1_o[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1024; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
        step(1, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, 10'($urandom_range(0, 1023)));
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (dir_o[k] !== m_pc[k] || id_o[k] !== m_id[k] || pc1_o[k] !== m_pc1[k] ||
                    val_o[k] !== m_v[k] || det_o[k] !== m_halt[k] || cnt_o[k] !== 16'(m_cnt[k])) begin
                    tests_failed++;
                    $display("FAIL random c%0d dut%0d got dir=%0d id=%h pc1=%0d v=%b det=%b cnt=%0d want dir=%0d id=%h pc1=%0d v=%b det=%b cnt=%0d",
                             c, k, dir_o[k], id_o[k], pc1_o[k], val_o[k], det_o[k], cnt_o[k],
                             m_pc[k], m_id[k], m_pc1[k], m_v[k], m_halt[k], m_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_id[k] = 0; m_pc1[k] = 0; m_v[k] = 0; m_halt[k] = 0; m_cnt[k] = 0;
        end
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt_exit();
        test_reset_in_halt();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
